// File: rtl/stim_vector_player_pkg.sv
// Shared types for the stimulus vector player: FSM state encoding and the
// two-bit {A,E} vector record driven into the DUT.
package stim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        DRIVE,
        GAP,
        DONE
    } stim_state_t;

    typedef struct packed {
        logic A;
        logic E;
    } stim_vec_t;

endpackage

// File: rtl/stim_vector_player_if.sv
// Control/table-load bus and DUT-drive outputs of the stimulus vector player.
// The master side loads the table and starts runs; the slave side is the player.
interface stim_vector_player_if #(
    parameter int NUM_VECTORS = 16
);
    import stim_pkg::*;

    localparam int IDX_W = $clog2(NUM_VECTORS);

    logic             wr_en;
    logic [IDX_W-1:0] wr_addr;
    stim_vec_t        wr_data;
    logic [IDX_W:0]   num_vec;
    logic             start;
    logic             abort;

    logic             dut_reset;
    logic             drv_A;
    logic             drv_E;
    logic             drv_valid;
    logic [IDX_W-1:0] vec_idx;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_data, num_vec, start, abort,
        input  dut_reset, drv_A, drv_E, drv_valid, vec_idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, num_vec, start, abort,
        output dut_reset, drv_A, drv_E, drv_valid, vec_idx, busy, done
    );

endinterface

// File: rtl/stim_vector_player_mem.sv
// Vector table: one synchronous write port, one asynchronous read port.
module stim_vec_mem
    import stim_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  stim_vec_t        wdata,
    input  logic [IDX_W-1:0] raddr,
    output stim_vec_t        rdata
);

    stim_vec_t mem [DEPTH];

    // NOTE: storage has no reset; contents are undefined until written, which keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stim_vector_player.sv
// Sequences DUT reset, then replays the preloaded {A,E} table one vector per
// DRIVE cycle with optional idle gaps. Every output is registered.
module stim_vector_player
    import stim_pkg::*;
#(
    parameter int NUM_VECTORS  = 16,
    parameter int RESET_CYCLES = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    stim_vector_player_if.slave   bus
);

    localparam int IDX_W   = $clog2(NUM_VECTORS);
    localparam int CNT_MAX = (RESET_CYCLES > GAP_CYCLES) ? RESET_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [IDX_W:0]   NUM_MAX  = (IDX_W+1)'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    stim_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W:0]   n_q, n_d;
    logic             last_vec;
    stim_vec_t        rd_vec;

    logic             dut_reset_q, dut_reset_d;
    stim_vec_t        ae_q, ae_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] vidx_q, vidx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Writes are gated by the registered busy, so a write issued with start still lands.
    stim_vec_mem #(.DEPTH(NUM_VECTORS), .IDX_W(IDX_W)) u_mem (
        .clk   (clk),
        .we    (bus.wr_en & ~busy_q),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .raddr (idx_d),
        .rdata (rd_vec)
    );

    assign last_vec = ({1'b0, idx_q} == (n_q - 1'b1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            n_q         <= '0;
            dut_reset_q <= 1'b1;
            ae_q        <= '0;
            valid_q     <= 1'b0;
            vidx_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            dut_reset_q <= dut_reset_d;
            ae_q        <= ae_d;
            valid_q     <= valid_d;
            vidx_q      <= vidx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        n_d     = n_q;
        if (bus.abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d = RST_HOLD;
                        cnt_d   = '0;
                        idx_d   = '0;
                        n_d     = (bus.num_vec > NUM_MAX) ? NUM_MAX : bus.num_vec;
                    end
                end
                RST_HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = (n_q == '0) ? DONE : DRIVE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DRIVE: begin
                    if (last_vec) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                        idx_d   = idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs follow the state being entered, so they line up with state_q after the edge.
    always_comb begin
        dut_reset_d = dut_reset_q;
        ae_d        = ae_q;
        valid_d     = 1'b0;
        vidx_d      = vidx_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        unique case (state_d)
            IDLE: begin
                dut_reset_d = 1'b1;
                ae_d        = '0;
                vidx_d      = '0;
            end
            RST_HOLD: begin
                dut_reset_d = 1'b1;
                busy_d      = 1'b1;
            end
            DRIVE: begin
                dut_reset_d = 1'b0;
                valid_d     = 1'b1;
                ae_d        = rd_vec;
                vidx_d      = idx_d;
                busy_d      = 1'b1;
            end
            GAP: begin
                dut_reset_d = 1'b0;
                busy_d      = 1'b1;
            end
            DONE: begin
                dut_reset_d = 1'b0;
                done_d      = 1'b1;
            end
            default: dut_reset_d = 1'b1;
        endcase
    end

    assign bus.dut_reset = dut_reset_q;
    assign bus.drv_A     = ae_q.A;
    assign bus.drv_E     = ae_q.E;
    assign bus.drv_valid = valid_q;
    assign bus.vec_idx   = vidx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_stim_vector_player.sv
// Self-checking bench for stim_vector_player: a fixed vector table for the
// reference run, hand sequences for abort/async reset, and randomized runs.
module tb_stim_vector_player;
    import stim_pkg::*;

    localparam int NV = 16;
    localparam int R  = 4;
    localparam int G  = 1;

    logic clk;
    logic reset;

    stim_vector_player_if #(.NUM_VECTORS(NV)) bus ();

    stim_vector_player #(.NUM_VECTORS(NV), .RESET_CYCLES(R), .GAP_CYCLES(G)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] model_tbl [NV];

    typedef struct {
        logic       rst_o;
        logic       valid;
        logic       chk_ae;
        logic [1:0] ae;
        int         idx;
        logic       busy;
        logic       done;
    } step_t;

    step_t steps [12];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_entry(input int addr, input logic [1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(addr);
        bus.wr_data = stim_vec_t'(data);
        tick();
        bus.wr_en   = 1'b0;
        model_tbl[addr] = data;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " dut_reset"}, 32'(bus.dut_reset), 1);
        check({tag, " busy"},      32'(bus.busy), 0);
        check({tag, " done"},      32'(bus.done), 0);
        check({tag, " drv_valid"}, 32'(bus.drv_valid), 0);
        check({tag, " ae"},        32'({bus.drv_A, bus.drv_E}), 0);
        check({tag, " vec_idx"},   32'(bus.vec_idx), 0);
    endtask

    // Reference run: timing derived from the cycle formulas, data from the model table.
    task automatic run_model(input int nreq, input string tag);
        int n, done_c, k, kk;
        logic exp_valid;
        string nm;
        n      = (nreq > NV) ? NV : nreq;
        done_c = (n == 0) ? R + 1 : R + 1 + (n - 1) * (G + 1) + 1;
        bus.num_vec = 5'(nreq);
        bus.start   = 1'b1;
        for (int c = 1; c <= done_c + 1; c++) begin
            tick();
            bus.start = 1'b0;
            nm = $sformatf("%s c%0d", tag, c);
            k  = (c - R - 1) / (G + 1);
            exp_valid = (c > R) && (c < done_c) && (((c - R - 1) % (G + 1)) == 0);
            check({nm, " dut_reset"}, 32'(bus.dut_reset), (c <= R) ? 1 : 0);
            check({nm, " busy"},      32'(bus.busy), (c < done_c) ? 1 : 0);
            check({nm, " done"},      32'(bus.done), (c >= done_c) ? 1 : 0);
            check({nm, " drv_valid"}, 32'(bus.drv_valid), 32'(exp_valid));
            if (c > R && n > 0) begin
                kk = (c < done_c) ? k : n - 1;
                check({nm, " ae"},      32'({bus.drv_A, bus.drv_E}), 32'(model_tbl[kk]));
                check({nm, " vec_idx"}, 32'(bus.vec_idx), kk);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.num_vec = '0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;

        // 1. reset only
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");

        // 2. table-driven reference run; entry 3 is written in the start cycle
        steps[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 0, 1'b1, 1'b0};
        steps[1]  = '{1'b1, 1'b0, 1'b0, 2'b00, 0, 1'b1, 1'b0};
        steps[2]  = '{1'b1, 1'b0, 1'b0, 2'b00, 0, 1'b1, 1'b0};
        steps[3]  = '{1'b1, 1'b0, 1'b0, 2'b00, 0, 1'b1, 1'b0};
        steps[4]  = '{1'b0, 1'b1, 1'b1, 2'b01, 0, 1'b1, 1'b0};
        steps[5]  = '{1'b0, 1'b0, 1'b1, 2'b01, 0, 1'b1, 1'b0};
        steps[6]  = '{1'b0, 1'b1, 1'b1, 2'b10, 1, 1'b1, 1'b0};
        steps[7]  = '{1'b0, 1'b0, 1'b1, 2'b10, 1, 1'b1, 1'b0};
        steps[8]  = '{1'b0, 1'b1, 1'b1, 2'b11, 2, 1'b1, 1'b0};
        steps[9]  = '{1'b0, 1'b0, 1'b1, 2'b11, 2, 1'b1, 1'b0};
        steps[10] = '{1'b0, 1'b1, 1'b1, 2'b00, 3, 1'b1, 1'b0};
        steps[11] = '{1'b0, 1'b0, 1'b1, 2'b00, 3, 1'b0, 1'b1};
        write_entry(0, 2'b01);
        write_entry(1, 2'b10);
        write_entry(2, 2'b11);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd3;
        bus.wr_data = stim_vec_t'(2'b00);
        model_tbl[3] = 2'b00;
        bus.num_vec = 5'd4;
        bus.start   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            bus.wr_en = 1'b0;
            bus.start = 1'b0;
            check($sformatf("tbl c%0d dut_reset", i + 1), 32'(bus.dut_reset), 32'(steps[i].rst_o));
            check($sformatf("tbl c%0d drv_valid", i + 1), 32'(bus.drv_valid), 32'(steps[i].valid));
            check($sformatf("tbl c%0d busy", i + 1),      32'(bus.busy), 32'(steps[i].busy));
            check($sformatf("tbl c%0d done", i + 1),      32'(bus.done), 32'(steps[i].done));
            if (steps[i].chk_ae) begin
                check($sformatf("tbl c%0d ae", i + 1),      32'({bus.drv_A, bus.drv_E}), 32'(steps[i].ae));
                check($sformatf("tbl c%0d vec_idx", i + 1), 32'(bus.vec_idx), steps[i].idx);
            end
        end

        // 3. empty run
        run_model(0, "nvec0");

        // 4. oversized request clamps to the table depth
        for (int a = 0; a < NV; a++) write_entry(a, 2'($urandom_range(0, 3)));
        run_model(20, "nvec20");

        // 5. abort on the second DRIVE cycle, with an ignored write mid-run
        bus.num_vec = 5'd4;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd0;
        bus.wr_data = stim_vec_t'(~model_tbl[0]);
        tick();
        bus.wr_en = 1'b0;
        repeat (4) tick();
        check("abort pre drv_valid", 32'(bus.drv_valid), 1);
        check("abort pre vec_idx",   32'(bus.vec_idx), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_idle_outputs("abort");
        tick();
        check_idle_outputs("abort hold");
        run_model(4, "post_abort");

        // abort wins over a simultaneous start in DONE
        bus.abort   = 1'b1;
        bus.start   = 1'b1;
        bus.num_vec = 5'd2;
        tick();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check_idle_outputs("abort_vs_start");

        // 6. async reset between edges during GAP, then a clean replay
        bus.num_vec = 5'd4;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("gap drv_valid", 32'(bus.drv_valid), 0);
        check("gap busy",      32'(bus.busy), 1);
        #2 reset = 1'b1;
        #1 check_idle_outputs("async_rst");
        @(negedge clk);
        reset = 1'b0;
        run_model(4, "post_rst");

        // randomized runs against the reference model
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 3; w++)
                write_entry(int'($urandom_range(0, NV - 1)), 2'($urandom_range(0, 3)));
            run_model(int'($urandom_range(0, 20)), $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
